// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared control-word layout for the ID/EXE/MEM pipeline stages
package cpu_pipe_pkg;

    localparam int CTRL_W       = 5;
    localparam int CTRL_WE_MEM  = 0;
    localparam int CTRL_SEL_DAT = 1;
    localparam int CTRL_SEL_C   = 2;
    localparam int CTRL_SEL_V   = 3;
    localparam int CTRL_WE_C    = 4;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one pipeline entry: payload plus valid bit with load/clear/hold
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Clear only drops the valid bit; the payload is left stale.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// rtl/exe_mem_pipe_reg.sv - EXE to MEM valid/ready boundary register with 2-entry skid buffer
module exe_mem_pipe_reg #(
    parameter int RES_W     = 32,
    parameter int BYTE_W    = 8,
    parameter int RG_W      = 4,
    parameter int CTRL_W    = cpu_pipe_pkg::CTRL_W,
    parameter bit ZERO_CTRL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [RES_W-1:0]  result_in,
    input  logic [BYTE_W-1:0] dob_byte_in,
    input  logic [RG_W-1:0]   rg_exe,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [RES_W-1:0]  result,
    output logic [BYTE_W-1:0] dob_byte,
    output logic [RG_W-1:0]   rg_mem,
    output logic [1:0]        occ
);

    localparam int PW = CTRL_W + RES_W + BYTE_W + RG_W;

    logic          main_v, skid_v;
    logic [PW-1:0] in_pay, main_pay, skid_pay, main_in;
    logic          main_load, main_clr, main_from_skid, skid_load, skid_clr;
    logic          accept, drain, in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] ctrl_raw;

    assign in_pay = {ctrl_in, result_in, dob_byte_in, rg_exe};
    assign accept = in_valid & in_ready_q;
    assign drain  = main_v & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!main_v) begin
            main_load = accept;
        end else if (drain) begin
            if (skid_v) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_load      = accept;
                skid_clr       = !accept;
            end else begin
                main_load = accept;
                main_clr  = !accept;
            end
        end else begin
            skid_load = accept;
        end
    end

    assign main_in = main_from_skid ? skid_pay : in_pay;

    // Ready is precomputed from the skid entry's next state so MEM stalls never reach EXE combinationally.
    always_comb begin
        in_ready_d = !(skid_load | (skid_v & !skid_clr));
        if (skid_clr) begin
            in_ready_d = !skid_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    pipe_entry_reg #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_in),
        .valid (main_v),
        .q     (main_pay)
    );

    pipe_entry_reg #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_pay),
        .valid (skid_v),
        .q     (skid_pay)
    );

    assign {ctrl_raw, result, dob_byte, rg_mem} = main_pay;

    // Bubbles carry no write enables downstream.
    assign ctrl_out  = (ZERO_CTRL && !main_v) ? '0 : ctrl_raw;
    assign out_valid = main_v;
    assign in_ready  = in_ready_q;
    assign occ       = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb/tb_exe_mem_pipe_reg.sv - self-checking bench for exe_mem_pipe_reg
module tb_exe_mem_pipe_reg;
    import cpu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [4:0]  ctrl_in = '0;
    logic [31:0] result_in = '0;
    logic [7:0]  dob_byte_in = '0;
    logic [3:0]  rg_exe = '0;
    logic        in_ready, out_valid;
    logic [4:0]  ctrl_out;
    logic [31:0] result;
    logic [7:0]  dob_byte;
    logic [3:0]  rg_mem;
    logic [1:0]  occ;

    logic        in_valid_s = 1'b0, out_ready_s = 1'b1;
    logic [4:0]  ctrl_in_s = '0;
    logic [15:0] result_in_s = '0;
    logic [3:0]  dob_in_s = '0;
    logic [4:0]  rg_exe_s = '0;
    logic        in_ready_s, out_valid_s;
    logic [4:0]  ctrl_out_s;
    logic [15:0] result_s;
    logic [3:0]  dob_s;
    logic [4:0]  rg_mem_s;
    logic [1:0]  occ_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exe_mem_pipe_reg u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .result_in(result_in), .dob_byte_in(dob_byte_in),
        .rg_exe(rg_exe), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .result(result), .dob_byte(dob_byte), .rg_mem(rg_mem),
        .occ(occ)
    );

    exe_mem_pipe_reg #(.RES_W(16), .BYTE_W(4), .RG_W(5)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .ctrl_in(ctrl_in_s), .result_in(result_in_s), .dob_byte_in(dob_in_s),
        .rg_exe(rg_exe_s), .flush(1'b0), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .ctrl_out(ctrl_out_s), .result(result_s), .dob_byte(dob_s), .rg_mem(rg_mem_s),
        .occ(occ_s)
    );

    // Reference: an in-order queue of at most two accepted instructions.
    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] res;
        logic [7:0]  dob;
        logic [3:0]  rg;
    } ent_t;
    ent_t mq[$];

    task automatic model_edge();
        bit acc, drn;
        if (rst) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back('{ctrl_in, result_in, dob_byte_in, rg_exe});
            if (flush) mq.delete();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("rnd out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        chk("rnd in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
        chk("rnd occ", {30'b0, occ}, mq.size());
        if (mq.size() > 0) begin
            chk("rnd ctrl_out", {27'b0, ctrl_out}, {27'b0, mq[0].ctrl});
            chk("rnd result", result, mq[0].res);
            chk("rnd dob_byte", {24'b0, dob_byte}, {24'b0, mq[0].dob});
            chk("rnd rg_mem", {28'b0, rg_mem}, {28'b0, mq[0].rg});
        end else begin
            chk("rnd bubble ctrl", {27'b0, ctrl_out}, 32'h0);
        end
    endtask

    typedef struct {
        logic        r, iv, ordy, fl;
        logic [4:0]  c;
        logic [31:0] res;
        logic [3:0]  rg;
        logic        ov, ir;
        logic [1:0]  oc;
        logic [4:0]  ec;
        logic [31:0] er;
        logic [3:0]  erg;
    } vec_t;

    function automatic vec_t v(logic r, logic iv, logic ordy, logic fl, logic [4:0] c,
                               logic [31:0] res, logic [3:0] rg, logic ov, logic ir,
                               logic [1:0] oc, logic [4:0] ec, logic [31:0] er, logic [3:0] erg);
        vec_t t;
        t.r = r; t.iv = iv; t.ordy = ordy; t.fl = fl; t.c = c; t.res = res; t.rg = rg;
        t.ov = ov; t.ir = ir; t.oc = oc; t.ec = ec; t.er = er; t.erg = erg;
        return t;
    endfunction

    localparam logic [31:0] A = 32'hDEAD_BEEF, B = 32'h0000_0B0B, C = 32'h0000_0C0C;
    localparam logic [31:0] D = 32'h0000_D0D0, E = 32'h0000_E0E0, F = 32'h0000_F0F0;
    localparam logic [31:0] G = 32'h1111_0000, H = 32'h2222_0000, I = 32'h3333_0000;
    localparam logic [31:0] J = 32'h0000_4444, K = 32'h0000_5555;

    vec_t vt[22];

    initial begin
        for (int i = 0; i < 3; i++) vt[i] = v(1, 1, 0, 0, 5'h1F, 32'h1111, 4'h1, 0, 1, 0, 0, 0, 0);
        vt[3]  = v(0, 1, 0, 0, 5'h01, A, 4'h3, 1, 1, 1, 5'h01, A, 4'h3);
        vt[4]  = v(0, 1, 0, 0, 5'h02, B, 4'h5, 1, 0, 2, 5'h01, A, 4'h3);
        vt[5]  = v(0, 1, 0, 0, 5'h04, C, 4'h6, 1, 0, 2, 5'h01, A, 4'h3);
        vt[6]  = v(0, 1, 0, 0, 5'h04, C, 4'h6, 1, 0, 2, 5'h01, A, 4'h3);
        vt[7]  = v(0, 1, 1, 0, 5'h04, C, 4'h6, 1, 1, 1, 5'h02, B, 4'h5);
        vt[8]  = v(0, 1, 1, 0, 5'h04, C, 4'h6, 1, 1, 1, 5'h04, C, 4'h6);
        vt[9]  = v(0, 0, 1, 0, 5'h00, 0, 4'h0, 0, 1, 0, 0, 0, 0);
        vt[10] = v(0, 1, 0, 0, 5'h08, D, 4'h7, 1, 1, 1, 5'h08, D, 4'h7);
        vt[11] = v(0, 1, 0, 0, 5'h10, E, 4'h8, 1, 0, 2, 5'h08, D, 4'h7);
        vt[12] = v(0, 1, 0, 1, 5'h1F, F, 4'h9, 0, 1, 0, 0, 0, 0);
        vt[13] = v(0, 1, 0, 0, 5'h1F, G, 4'hA, 1, 1, 1, 5'h1F, G, 4'hA);
        vt[14] = v(0, 1, 1, 1, 5'h03, H, 4'hB, 0, 1, 0, 0, 0, 0);
        vt[15] = v(0, 0, 1, 0, 5'h00, 0, 4'h0, 0, 1, 0, 0, 0, 0);
        vt[16] = v(0, 1, 1, 0, 5'h11, I, 4'hC, 1, 1, 1, 5'h11, I, 4'hC);
        vt[17] = v(0, 0, 1, 0, 5'h00, 0, 4'h0, 0, 1, 0, 0, 0, 0);
        vt[18] = v(0, 0, 1, 0, 5'h00, 0, 4'h0, 0, 1, 0, 0, 0, 0);
        vt[19] = v(0, 1, 0, 0, 5'h03, J, 4'hD, 1, 1, 1, 5'h03, J, 4'hD);
        vt[20] = v(0, 1, 0, 0, 5'h0C, K, 4'hE, 1, 0, 2, 5'h03, J, 4'hD);
        vt[21] = v(1, 1, 0, 0, 5'h1F, K, 4'hE, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            rst = vt[i].r; in_valid = vt[i].iv; out_ready = vt[i].ordy; flush = vt[i].fl;
            ctrl_in = vt[i].c; result_in = vt[i].res; dob_byte_in = vt[i].res[7:0];
            rg_exe = vt[i].rg;
            cycle();
            chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ov});
            chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].ir});
            chk($sformatf("vec%0d occ", i), {30'b0, occ}, {30'b0, vt[i].oc});
            chk($sformatf("vec%0d ctrl_out", i), {27'b0, ctrl_out}, {27'b0, vt[i].ec});
            if (vt[i].ov || vt[i].r) begin
                chk($sformatf("vec%0d result", i), result, vt[i].er);
                chk($sformatf("vec%0d dob_byte", i), {24'b0, dob_byte}, {24'b0, vt[i].er[7:0]});
                chk($sformatf("vec%0d rg_mem", i), {28'b0, rg_mem}, {28'b0, vt[i].erg});
            end
        end

        // Small instance was reset alongside the table's reset rows.
        chk("small reset occ", {30'b0, occ_s}, 32'h0);
        chk("small reset result", {16'b0, result_s}, 32'h0);

        rst = 1'b0; flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; result_in = i; dob_byte_in = 8'(i);
            rg_exe = 4'(i); ctrl_in = 5'(i);
            in_valid_s = 1'b1; out_ready_s = 1'b1; result_in_s = 16'(i + 16'h100);
            dob_in_s = 4'(i); rg_exe_s = 5'(i + 16); ctrl_in_s = 5'(i + 1);
            cycle();
            chk($sformatf("stream%0d out_valid", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("stream%0d result", i), result, i);
            chk($sformatf("stream%0d in_ready", i), {31'b0, in_ready}, 32'h1);
            chk($sformatf("stream%0d occ", i), {30'b0, occ}, 32'h1);
            chk($sformatf("small%0d out_valid", i), {31'b0, out_valid_s}, 32'h1);
            chk($sformatf("small%0d result", i), {16'b0, result_s}, i + 32'h100);
            chk($sformatf("small%0d rg_mem", i), {27'b0, rg_mem_s}, i + 16);
            chk($sformatf("small%0d in_ready", i), {31'b0, in_ready_s}, 32'h1);
            chk($sformatf("small%0d occ", i), {30'b0, occ_s}, 32'h1);
        end
        in_valid = 1'b0; in_valid_s = 1'b0;
        cycle();
        chk("stream drained", {31'b0, out_valid}, 32'h0);
        chk("small drained", {31'b0, out_valid_s}, 32'h0);
        chk("small bubble ctrl", {27'b0, ctrl_out_s}, 32'h0);

        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(63) == 0);
            flush     = ($urandom_range(15) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(1) == 1);
            ctrl_in   = 5'($urandom);
            result_in = $urandom;
            dob_byte_in = 8'($urandom);
            rg_exe    = 4'($urandom);
            cycle();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
